// File: rtl/pixel_rate_converter.sv
// Pixel-rate converter: a phase accumulator on clk30 emits one-cycle pixel ticks at
// inc_active/2^ACC_W of the clock rate, re-aligned and re-rated only at line_start.
module pixel_rate_converter #(
  parameter int ACC_W    = 10,
  parameter int BASE_INC = 256,
  parameter int VCD_INC  = 235,
  parameter int LINE_PIX = 384,
  parameter int PIX_W    = 10
) (
  input  logic             clk30,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             cfg_wr,
  input  logic [ACC_W-1:0] inc_cfg,
  input  logic             line_start,
  output logic             newpixel,
  output logic [PIX_W-1:0] pixel_idx,
  output logic             line_full
);

  localparam logic [ACC_W-1:0] BASE_INC_C = ACC_W'(BASE_INC);
  localparam logic [ACC_W-1:0] VCD_INC_C  = ACC_W'(VCD_INC);
  localparam logic [PIX_W:0]   LINE_PIX_C = (PIX_W+1)'(LINE_PIX);
  localparam logic [1:0]       MODE_BASE  = 2'd0;
  localparam logic [1:0]       MODE_VCD   = 2'd1;
  localparam logic [1:0]       MODE_PROG  = 2'd2;
  localparam logic [1:0]       MODE_HALT  = 2'd3;

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] cfg_r;
  logic [ACC_W-1:0] inc_active_r;
  logic [1:0]       mode_active_r;
  logic [PIX_W:0]   pix_cnt_r;
  logic             newpixel_r;
  logic [PIX_W-1:0] pixel_idx_r;
  logic             line_full_r;

  logic [ACC_W:0]   sum_s;
  logic [PIX_W:0]   pix_next_s;
  logic [ACC_W-1:0] cfg_eff_s;
  logic [ACC_W-1:0] inc_sel_s;
  logic             run_s;

  // Next-state arithmetic and the increment chosen for the next line.
  always_comb begin
    sum_s      = {1'b0, acc_r} + {1'b0, inc_active_r};
    pix_next_s = pix_cnt_r + {{PIX_W{1'b0}}, 1'b1};
    run_s      = (mode_active_r != MODE_HALT) && !line_full_r;
    // A write landing on the line_start edge is honoured immediately.
    if (cfg_wr) begin
      cfg_eff_s = inc_cfg;
    end else begin
      cfg_eff_s = cfg_r;
    end
    case (mode)
      MODE_BASE: inc_sel_s = BASE_INC_C;
      MODE_VCD:  inc_sel_s = VCD_INC_C;
      MODE_PROG: inc_sel_s = cfg_eff_s;
      default:   inc_sel_s = inc_active_r;
    endcase
  end

  // Programmable increment shadow register, writable in any cycle.
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      cfg_r <= BASE_INC_C;
    end else if (cfg_wr) begin
      cfg_r <= inc_cfg;
    end
  end

  // Phase accumulator, pixel counter and registered tick outputs.
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      acc_r         <= {ACC_W{1'b0}};
      inc_active_r  <= BASE_INC_C;
      mode_active_r <= MODE_BASE;
      pix_cnt_r     <= {(PIX_W+1){1'b0}};
      newpixel_r    <= 1'b0;
      pixel_idx_r   <= {PIX_W{1'b0}};
      line_full_r   <= 1'b0;
    end else if (line_start) begin
      // Line alignment beats a coincident overflow; pixel_idx deliberately survives.
      mode_active_r <= mode;
      inc_active_r  <= inc_sel_s;
      acc_r         <= {ACC_W{1'b0}};
      pix_cnt_r     <= {(PIX_W+1){1'b0}};
      line_full_r   <= 1'b0;
      newpixel_r    <= 1'b0;
    end else if (run_s) begin
      acc_r      <= sum_s[ACC_W-1:0];
      newpixel_r <= sum_s[ACC_W];
      if (sum_s[ACC_W]) begin
        pixel_idx_r <= pix_cnt_r[PIX_W-1:0];
        pix_cnt_r   <= pix_next_s;
        line_full_r <= (pix_next_s == LINE_PIX_C);
      end
    end else begin
      newpixel_r <= 1'b0;
    end
  end

  assign newpixel  = newpixel_r;
  assign pixel_idx = pixel_idx_r;
  assign line_full = line_full_r;

endmodule

// File: tb/tb_pixel_rate_converter.sv
// Directed self-checking bench for pixel_rate_converter: a default instance plus a
// short-line instance (LINE_PIX=8, BASE_INC=512) for the line-full corner.
module tb_pixel_rate_converter;

  typedef struct {
    logic       line_start;
    logic [1:0] mode;
    logic       exp_np;
    logic [9:0] exp_idx;
    logic       exp_full;
  } vec_t;

  logic       clk30;
  logic       reset_n;
  logic [1:0] mode;
  logic       cfg_wr;
  logic [9:0] inc_cfg;
  logic       line_start;
  logic       newpixel;
  logic [9:0] pixel_idx;
  logic       line_full;

  logic       reset_n2;
  logic       line_start2;
  logic       newpixel2;
  logic [9:0] pixel_idx2;
  logic       line_full2;

  int checks = 0;
  int errors = 0;
  vec_t vec [12];

  pixel_rate_converter dut (
    .clk30(clk30), .reset_n(reset_n), .mode(mode), .cfg_wr(cfg_wr),
    .inc_cfg(inc_cfg), .line_start(line_start), .newpixel(newpixel),
    .pixel_idx(pixel_idx), .line_full(line_full)
  );

  pixel_rate_converter #(.LINE_PIX(8), .BASE_INC(512)) dut_short (
    .clk30(clk30), .reset_n(reset_n2), .mode(2'd0), .cfg_wr(1'b0),
    .inc_cfg(10'd0), .line_start(line_start2), .newpixel(newpixel2),
    .pixel_idx(pixel_idx2), .line_full(line_full2)
  );

  initial clk30 = 1'b0;
  always #5 clk30 = ~clk30;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk30);
    #1;
  endtask

  // Runs n cycles of a free-running periodic line, checking every cycle.
  task automatic periodic(input string name, input int n, input int period, input int idx0);
    for (int k = 1; k <= n; k++) begin
      step();
      check($sformatf("%s np k=%0d", name, k), 32'(newpixel), 32'((k % period) == 0));
      if ((k % period) == 0)
        check($sformatf("%s idx k=%0d", name, k), 32'(pixel_idx), 32'(idx0 + k / period - 1));
    end
  endtask

  initial begin
    int ticks, last, maxgap, mingap;

    for (int i = 0; i < 12; i++)
      vec[i] = '{1'b0, 2'd0, 1'b0, 10'd0, 1'b0};
    vec[3]  = '{1'b0, 2'd0, 1'b1, 10'd0, 1'b0};
    vec[4]  = '{1'b0, 2'd0, 1'b0, 10'd0, 1'b0};
    vec[6]  = '{1'b0, 2'd0, 1'b0, 10'd0, 1'b0};
    vec[7]  = '{1'b0, 2'd0, 1'b1, 10'd1, 1'b0};
    vec[8]  = '{1'b0, 2'd0, 1'b0, 10'd1, 1'b0};
    vec[9]  = '{1'b0, 2'd0, 1'b0, 10'd1, 1'b0};
    vec[10] = '{1'b0, 2'd0, 1'b0, 10'd1, 1'b0};
    vec[11] = '{1'b0, 2'd0, 1'b1, 10'd2, 1'b0};

    reset_n = 1'b0; reset_n2 = 1'b0;
    mode = 2'd0; cfg_wr = 1'b0; inc_cfg = 10'd0; line_start = 1'b0; line_start2 = 1'b0;
    repeat (3) step();
    check("reset np", 32'(newpixel), 32'd0);
    check("reset idx", 32'(pixel_idx), 32'd0);
    check("reset full", 32'(line_full), 32'd0);

    // Base rate straight out of reset, no line_start needed.
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      line_start = vec[i].line_start;
      mode = vec[i].mode;
      step();
      check($sformatf("base np c=%0d", i + 1), 32'(newpixel), 32'(vec[i].exp_np));
      check($sformatf("base idx c=%0d", i + 1), 32'(pixel_idx), 32'(vec[i].exp_idx));
      check($sformatf("base full c=%0d", i + 1), 32'(line_full), 32'(vec[i].exp_full));
    end
    for (int k = 13; k <= 40; k++) begin
      step();
      check($sformatf("base np c=%0d", k), 32'(newpixel), 32'((k % 4) == 0));
      if ((k % 4) == 0) check($sformatf("base idx c=%0d", k), 32'(pixel_idx), 32'(k / 4 - 1));
    end

    // VCD rate over 1024 cycles; a mid-line cfg write must not disturb it.
    mode = 2'd1; line_start = 1'b1;
    step();
    check("vcd ls np", 32'(newpixel), 32'd0);
    line_start = 1'b0;
    ticks = 0; last = 0; maxgap = 0; mingap = 1000;
    for (int k = 1; k <= 1024; k++) begin
      cfg_wr = (k == 3); inc_cfg = 10'd512;
      step();
      if (newpixel) begin
        if (ticks > 0) begin
          if (k - last > maxgap) maxgap = k - last;
          if (k - last < mingap) mingap = k - last;
        end
        ticks++; last = k;
      end
    end
    cfg_wr = 1'b0;
    check("vcd ticks", 32'(ticks), 32'd235);
    check("vcd maxgap<=5", 32'(maxgap <= 5), 32'd1);
    check("vcd mingap>=2", 32'(mingap >= 2), 32'd1);
    check("vcd last idx", 32'(pixel_idx), 32'd234);

    // Programmable 512: every 2 cycles; a mid-line write of 256 is ignored.
    mode = 2'd2; line_start = 1'b1;
    step();
    line_start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cfg_wr = (k == 5); inc_cfg = 10'd256;
      step();
      check($sformatf("prog512 np k=%0d", k), 32'(newpixel), 32'((k % 2) == 0));
    end
    cfg_wr = 1'b0;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    periodic("prog256", 16, 4, 0);

    // Write-through: cfg_wr coincident with line_start uses the new value.
    line_start = 1'b1; cfg_wr = 1'b1; inc_cfg = 10'd128;
    step();
    line_start = 1'b0; cfg_wr = 1'b0;
    periodic("prog128", 24, 8, 0);

    // Overflow coinciding with line_start: line_start wins, idx held.
    mode = 2'd0; line_start = 1'b1;
    step();
    line_start = 1'b0;
    repeat (3) step();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    check("coinc np", 32'(newpixel), 32'd0);
    check("coinc acc", 32'(dut.acc_r), 32'd0);
    check("coinc idx held", 32'(pixel_idx), 32'd2);
    periodic("after coinc", 4, 4, 0);

    // Halt mode: no ticks, accumulator frozen.
    mode = 2'd3; line_start = 1'b1;
    step();
    line_start = 1'b0;
    ticks = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (newpixel) ticks++;
    end
    check("halt ticks", 32'(ticks), 32'd0);
    check("halt acc", 32'(dut.acc_r), 32'd0);

    // Asynchronous reset mid-line, then base timing restarts cleanly.
    mode = 2'd0; line_start = 1'b1;
    step();
    line_start = 1'b0;
    periodic("pre reset", 8, 4, 0);
    #3 reset_n = 1'b0;
    #1;
    check("async rst np", 32'(newpixel), 32'd0);
    check("async rst idx", 32'(pixel_idx), 32'd0);
    check("async rst full", 32'(line_full), 32'd0);
    step();
    reset_n = 1'b1;
    periodic("post reset", 12, 4, 0);

    // Short line: 8 ticks every 2 cycles, then line_full stops ticking.
    reset_n2 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("short np k=%0d", k), 32'(newpixel2), 32'((k % 2) == 0));
      check($sformatf("short idx k=%0d", k), 32'(pixel_idx2), 32'((k >= 2) ? (k / 2 - 1) : 0));
      check($sformatf("short full k=%0d", k), 32'(line_full2), 32'(k == 16));
    end
    ticks = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (newpixel2) ticks++;
    end
    check("short full ticks", 32'(ticks), 32'd0);
    check("short full held", 32'(line_full2), 32'd1);
    check("short idx held", 32'(pixel_idx2), 32'd7);
    line_start2 = 1'b1;
    step();
    line_start2 = 1'b0;
    check("short ls full", 32'(line_full2), 32'd0);
    check("short ls idx", 32'(pixel_idx2), 32'd7);
    step();
    step();
    check("short restart np", 32'(newpixel2), 32'd1);
    check("short restart idx", 32'(pixel_idx2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
